node_snapshot_streamer: RTL

- Sits directly downstream of a simulation core; consumes the per-node x/y positions the core produces.
- On each end-of-step pulse, captures all node positions into a shadow bank in one cycle.
- Streams the captured positions out, one node per transfer, over a valid/ready handshake to a readout/display consumer.
- The core keeps integrating while a snapshot drains; snapshots requested while streaming are dropped and counted.

---
 rtl/node_snapshot_streamer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/node_snapshot_streamer.sv
// Captures per-node x/y positions on step_done and streams them out one node per valid/ready transfer.
// Optional `SNAPSHOT_FRAME_ID_EN adds an out_frame snapshot sequence number.
module node_snapshot_streamer #(
    parameter int NODE_COUNT = 5,
    parameter int WIDTH      = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        step_done,
    input  logic [NODE_COUNT*WIDTH-1:0] x_pos_flat,
    input  logic [NODE_COUNT*WIDTH-1:0] y_pos_flat,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [7:0]                  out_index,
    output logic [WIDTH-1:0]            out_x,
    output logic [WIDTH-1:0]            out_y,
    output logic                        out_last,
    output logic                        busy,
    output logic [15:0]                 dropped_count
`ifdef SNAPSHOT_FRAME_ID_EN
    ,
    output logic [15:0]                 out_frame
`endif
);

    localparam int         IW       = (NODE_COUNT > 1) ? $clog2(NODE_COUNT) : 1;
    localparam logic [7:0] LAST_IDX = 8'(NODE_COUNT - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t            state_r, state_next_s;
    logic [WIDTH-1:0]  shadow_x_r [NODE_COUNT];
    logic [WIDTH-1:0]  shadow_y_r [NODE_COUNT];
    logic [7:0]        index_r;
    logic [WIDTH-1:0]  out_x_r, out_y_r;
    logic              out_last_r;
    logic [15:0]       dropped_r;
    logic              xfer_s, accept_s, drop_s;
    logic [7:0]        nxt_idx_s;

    // A snapshot is taken from IDLE, or when the final entry leaves in the same cycle.
    assign xfer_s    = (state_r == STREAM) && out_ready;
    assign accept_s  = step_done && ((state_r == IDLE) || (xfer_s && out_last_r));
    assign drop_s    = step_done && (state_r == STREAM) && !accept_s;
    assign nxt_idx_s = index_r + 8'd1;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = STREAM;
                end else begin
                    state_next_s = IDLE;
                end
            end
            STREAM: begin
                if (xfer_s && out_last_r && !step_done) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = STREAM;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Shadow bank capture and registered entry presentation.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NODE_COUNT; i++) begin
                shadow_x_r[i] <= '0;
                shadow_y_r[i] <= '0;
            end
            index_r    <= 8'd0;
            out_x_r    <= '0;
            out_y_r    <= '0;
            out_last_r <= 1'b0;
        end else if (accept_s) begin
            for (int i = 0; i < NODE_COUNT; i++) begin
                shadow_x_r[i] <= x_pos_flat[i*WIDTH +: WIDTH];
                shadow_y_r[i] <= y_pos_flat[i*WIDTH +: WIDTH];
            end
            index_r    <= 8'd0;
            out_x_r    <= x_pos_flat[WIDTH-1:0];
            out_y_r    <= y_pos_flat[WIDTH-1:0];
            out_last_r <= (LAST_IDX == 8'd0);
        end else if (xfer_s && !out_last_r) begin
            index_r    <= nxt_idx_s;
            out_x_r    <= shadow_x_r[nxt_idx_s[IW-1:0]];
            out_y_r    <= shadow_y_r[nxt_idx_s[IW-1:0]];
            out_last_r <= (nxt_idx_s == LAST_IDX);
        end else if (xfer_s) begin
            out_last_r <= 1'b0;
        end else begin
            out_last_r <= out_last_r;
        end
    end

    // Saturating count of snapshots rejected while streaming.
    always_ff @(posedge clk) begin
        if (reset) begin
            dropped_r <= 16'd0;
        end else if (drop_s && (dropped_r != 16'hFFFF)) begin
            dropped_r <= dropped_r + 16'd1;
        end else begin
            dropped_r <= dropped_r;
        end
    end

`ifdef SNAPSHOT_FRAME_ID_EN
    logic [15:0] frame_cnt_r, out_frame_r;

    // Frame sequence number; the accepted snapshot takes the pre-increment value.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_r <= 16'd0;
            out_frame_r <= 16'd0;
        end else if (accept_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
            out_frame_r <= frame_cnt_r;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign out_frame = out_frame_r;
`endif

    assign out_valid     = (state_r == STREAM);
    assign busy          = (state_r == STREAM);
    assign out_index     = index_r;
    assign out_x         = out_x_r;
    assign out_y         = out_y_r;
    assign out_last      = out_last_r;
    assign dropped_count = dropped_r;

endmodule
